// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// registers the returned word with PC+4 and a valid flag into the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_SIZE = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted
);

    localparam logic [31:0] FETCH_LIMIT = 32'(MEM_SIZE * 4);

    logic        redirect;
    logic [31:0] next_target;
    logic        at_end;
    logic [31:0] pc_plus4;

    assign redirect    = jump | branch_taken;
    assign next_target = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
    assign at_end      = (pc_out >= FETCH_LIMIT);
    assign pc_plus4    = pc_out + 32'd4;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out         <= RESET_PC;
            if_id_instr    <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
            halted         <= 1'b0;
        end else if (redirect) begin
            // A redirect wins over stall, flush and halt, and restarts a halted stage.
            pc_out         <= next_target;
            if_id_instr    <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
            halted         <= 1'b0;
        end else if (halted) begin
            if_id_instr    <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
        end else if (!stall) begin
            if (at_end) begin
                halted         <= 1'b1;
                if_id_instr    <= 32'h0;
                if_id_pc_plus4 <= 32'h0;
                if_id_valid    <= 1'b0;
            end else if (flush) begin
                pc_out         <= pc_plus4;
                if_id_instr    <= 32'h0;
                if_id_pc_plus4 <= 32'h0;
                if_id_valid    <= 1'b0;
            end else begin
                pc_out         <= pc_plus4;
                if_id_instr    <= instr_in;
                if_id_pc_plus4 <= pc_plus4;
                if_id_valid    <= 1'b1;
            end
        end
    end

endmodule
